// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, NOP encoding
// and the fetch FSM state type.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, ins, valid} buffer catching an instruction that returns while the
// pipeline is stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     ins_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     ins_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [31:0]     ins_q;
    logic            valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            ins_q   <= NOP_INS;
            valid_q <= 1'b0;
        end else if (clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            ins_q   <= ins_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign ins_o   = ins_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack word fetches, honours stall
// and EX redirects, and delivers (pc, ins, valid) to the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     fetch_ins,
    output logic            fetch_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]     fetch_ins_q, fetch_ins_d;
    logic            fetch_valid_q, fetch_valid_d;

    logic            buf_load, buf_unload, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_ins;

    logic [XLEN-1:0] pc_inc, redirect_tgt;

    assign pc_inc       = pc_q + XLEN'(4);
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    fetch_skid_buf u_skid_buf (
        .clk      (clk),
        .reset    (reset),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .clear_i  (buf_clear),
        .pc_i     (pc_q),
        .ins_i    (imem_rdata),
        .pc_o     (buf_pc),
        .ins_o    (buf_ins),
        .valid_o  (buf_valid)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_ins_d   = fetch_ins_q;
        fetch_valid_d = fetch_valid_q;
        buf_load      = 1'b0;
        buf_unload    = 1'b0;
        buf_clear     = 1'b0;

        if (redirect_valid) begin
            // Redirect beats stall and any buffered or returning data.
            pc_d          = redirect_tgt;
            fetch_valid_d = 1'b0;
            fetch_ins_d   = NOP_INS;
            buf_clear     = 1'b1;
            case (state_q)
                StFetch: begin
                    addr_d  = pc_q;
                    state_d = imem_ack ? StFetch : StDrop;
                end
                StDrop:  state_d = imem_ack ? StFetch : StDrop;
                default: state_d = StFetch;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (!stall) begin
                            fetch_pc_d    = pc_q;
                            fetch_ins_d   = imem_rdata;
                            fetch_valid_d = 1'b1;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = StHold;
                        end
                    end else if (!stall) begin
                        fetch_valid_d = 1'b0;
                        fetch_ins_d   = NOP_INS;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        fetch_pc_d    = buf_pc;
                        fetch_ins_d   = buf_ins;
                        fetch_valid_d = buf_valid;
                        buf_unload    = 1'b1;
                        state_d       = StFetch;
                    end
                end
                StDrop: begin
                    if (imem_ack) state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            addr_q        <= '0;
            fetch_pc_q    <= '0;
            fetch_ins_q   <= NOP_INS;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_ins_q   <= fetch_ins_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign imem_req    = (state_q == StFetch) || (state_q == StDrop);
    assign imem_addr   = (state_q == StDrop) ? addr_q : pc_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_ins   = fetch_ins_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a random-latency memory and a program-order
// model predict each delivered (pc, ins); a monitor checks the outputs every cycle.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_ins;
    logic        fetch_valid;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fetch_pc       (fetch_pc),
        .fetch_ins      (fetch_ins),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    typedef enum int {ExpHold, ExpDeliver, ExpBubble} exp_e;

    int          n_checks = 0;
    int          n_fail = 0;
    entry_t      sb_q[$];
    exp_e        exp_next = ExpBubble;
    bit          exp_armed = 1'b0;
    logic [63:0] model_pc = '0;
    bit          stale = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    int          lat_mode = 0;
    int          force_mode = 0;
    logic [63:0] force_pc = '0;
    logic [63:0] prev_pc = '0;
    logic [31:0] prev_ins = NOP_INS;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int new_lat();
        return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom_range(0, 3))
            0:       t = {$urandom, $urandom};
            1:       t = 64'h100 + 64'($urandom_range(0, 255));
            2:       t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            default: t = 64'h203;
        endcase
        return t;
    endfunction

    // Memory, stimulus and reference model for the coming rising edge; called at a negedge.
    task automatic drive_cycle(input int p_stall, input int p_redir);
        bit          ack, st, rv;
        logic [63:0] rpc;
        ack = 1'b0;
        if (imem_req) begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = new_lat();
            end
            if (cnt == 0) begin
                ack  = 1'b1;
                busy = 1'b0;
            end else begin
                cnt--;
            end
        end
        st  = ($urandom_range(0, 99) < p_stall);
        rv  = ($urandom_range(0, 99) < p_redir);
        rpc = rand_target();
        case (force_mode)
            1: if (ack) begin rv = 1'b1; st = 1'b1; rpc = force_pc; force_mode = 0; end
            2: if (imem_req && !ack) begin rv = 1'b1; rpc = force_pc; force_mode = 0; end
            3: begin rv = 1'b1; rpc = force_pc; force_mode = 0; end
            default: ;
        endcase
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = ack ? mem_word(imem_addr) : $urandom;

        if (rv) begin
            if (ack && stale) stale = 1'b0;
            else if (imem_req && !ack) stale = 1'b1;
            sb_q.delete();
            model_pc = {rpc[63:2], 2'b00};
            exp_next = ExpBubble;
        end else begin
            if (ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    chk("imem_addr", imem_addr, model_pc);
                    sb_q.push_back({model_pc, mem_word(model_pc)});
                    model_pc = model_pc + 64'd4;
                end
            end
            exp_next = st ? ExpHold : ((sb_q.size() > 0) ? ExpDeliver : ExpBubble);
        end
        exp_armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        exp_armed      = 1'b0;
        #1;
        chk("async_rst_req", 64'(imem_req), 64'd0);
        chk("async_rst_valid", 64'(fetch_valid), 64'd0);
        sb_q.delete();
        model_pc = 64'h0;
        stale    = 1'b0;
        busy     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        entry_t e;
        #1;
        if (reset) begin
            chk("rst_valid", 64'(fetch_valid), 64'd0);
            chk("rst_pc", fetch_pc, 64'd0);
            chk("rst_ins", 64'(fetch_ins), 64'(NOP_INS));
            chk("rst_req", 64'(imem_req), 64'd0);
        end else if (exp_armed) begin
            case (exp_next)
                ExpHold: begin
                    chk("hold_valid", 64'(fetch_valid), 64'(prev_valid));
                    chk("hold_pc", fetch_pc, prev_pc);
                    chk("hold_ins", 64'(fetch_ins), 64'(prev_ins));
                end
                ExpBubble: begin
                    chk("bubble_valid", 64'(fetch_valid), 64'd0);
                    chk("bubble_ins", 64'(fetch_ins), 64'(NOP_INS));
                end
                default: begin
                    e = sb_q.pop_front();
                    chk("deliver_valid", 64'(fetch_valid), 64'd1);
                    chk("deliver_pc", fetch_pc, e.pc);
                    chk("deliver_ins", 64'(fetch_ins), 64'(e.ins));
                end
            endcase
        end
        prev_pc    = fetch_pc;
        prev_ins   = fetch_ins;
        prev_valid = fetch_valid;
    end

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        do_reset();

        // Zero-wait memory, then fixed 3-cycle latency, both without stall.
        lat_mode = 0;
        repeat (20) drive_cycle(0, 0);
        lat_mode = 2;
        repeat (24) drive_cycle(0, 0);

        // Random latency, stall and redirects.
        lat_mode = -1;
        repeat (600) drive_cycle(30, 6);

        // Redirect to an unaligned target on the same cycle as an ack, with stall.
        lat_mode   = 1;
        force_pc   = 64'h203;
        force_mode = 1;
        repeat (12) drive_cycle(0, 0);
        chk("force_on_ack_taken", 64'(force_mode), 64'd0);

        // Redirect while a slow request is outstanding, then reset in the middle of the drop.
        lat_mode   = 3;
        force_pc   = 64'h500;
        force_mode = 2;
        repeat (6) drive_cycle(0, 0);
        chk("force_pending_taken", 64'(force_mode), 64'd0);
        force_pc   = 64'h900;
        force_mode = 2;
        while (force_mode != 0 && n_checks < 100000) drive_cycle(0, 0);
        chk("drop_state_entered", 64'(stale), 64'd1);
        do_reset();

        // Restart at the reset PC, then jump to the top of the address space and wrap.
        lat_mode = 0;
        repeat (5) drive_cycle(0, 0);
        force_pc   = 64'hFFFF_FFFF_FFFF_FFFC;
        force_mode = 3;
        repeat (8) drive_cycle(0, 0);
        chk("force_wrap_taken", 64'(force_mode), 64'd0);
        repeat (40) drive_cycle(20, 0);

        // Drain: no more acks, stall released, every accepted instruction must come out.
        lat_mode = 1000;
        repeat (6) drive_cycle(0, 0);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
